switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//  Conditions raw slide-switch/push-button inputs before they reach the counter/display logic.
//  Per channel: 2-FF synchroniser, then a tick-sampled debounce filter.
//  Outputs clean levels plus single-cycle rise/fall pulses, e.g. to drive a count enable or step.
//  Sits between the board pins (prswi) and the counter/hex-display stage.
// PARAMETERS
//  WIDTH         8      number of input channels
//  TICKDIV       10000  clk cycles per sample tick (1 kHz at 10 MHz); must be >= 2
//  STABLE_TICKS  8      consecutive differing samples needed to accept a new level; must be >= 1
// PORTS
//  clk       in   1      system clock (10 MHz on gatemate board)
//  rst       in   1      synchronous, active-high reset
//  sw_raw    in   WIDTH  asynchronous raw switch/button levels
//  sw_db     out  WIDTH  debounced level per channel
//  sw_rise   out  WIDTH  1-cycle pulse when sw_db[i] goes 0->1
//  sw_fall   out  WIDTH  1-cycle pulse when sw_db[i] goes 1->0
//  tick      out  1      1-cycle sample strobe (exported for debug/other stages)
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): sync regs, sw_db, sw_rise, sw_fall, tick, prescaler and all channel counters = 0.
//  Reset dominates all other activity; asserting it mid-filter discards partial counts.
//  - Sync: s1 <= sw_raw; s2 <= s1. Only s2 feeds the filter. sw_raw is never used combinationally.
//  - Prescaler: counts 0..TICKDIV-1 and wraps to 0.
//    Registered tick = 1 for exactly the one cycle after the prescaler holds TICKDIV-1; period is exactly TICKDIV cycles.
//    The first tick after reset occurs TICKDIV cycles after rst is released.
//  - Per channel i: counter cnt[i], width clog2(STABLE_TICKS+1). Evaluated only on cycles with tick=1:
//    * s2[i] == sw_db[i]: cnt[i] <= 0 (any agreeing sample restarts the filter).
//    * s2[i] != sw_db[i] and cnt[i] == STABLE_TICKS-1: sw_db[i] <= s2[i]; cnt[i] <= 0.
//      On that same edge, sw_rise[i] <= s2[i] and sw_fall[i] <= ~s2[i].
//    * otherwise: cnt[i] <= cnt[i] + 1.
//    On non-tick cycles cnt[i] and sw_db[i] hold.
//  - sw_rise/sw_fall: registered and asserted in the same cycle sw_db changes; forced to 0 on every other cycle.
//    A channel can never assert rise and fall together.
//  - Channels are independent; simultaneous changes on several channels pulse in the same cycle.
//  - cnt never exceeds STABLE_TICKS-1 (no wrap).
//    With STABLE_TICKS=1, a new level is accepted on the first tick that samples it.
//  - Glitches fully between two ticks are invisible. A bounce is rejected unless it is sampled differently on STABLE_TICKS consecutive ticks.
//  - Latency: a clean step on sw_raw changes sw_db between (STABLE_TICKS-1)*TICKDIV+3 and STABLE_TICKS*TICKDIV+2 cycles later.
// TESTING (bench params TICKDIV=4, STABLE_TICKS=3, WIDTH=8)
//  1 Reset: rst=1 for 3 cycles with sw_raw=8'hFF -> sw_db=0, rise=fall=tick=0 during reset.
//    After release: tick pulses every 4 cycles; sw_db=8'hFF within 14 cycles; rise=8'hFF for exactly 1 cycle.
//  2 Clean press ch0: sw_raw 0->8'h01 held -> sw_db[0]=1 after 11..14 cycles.
//    sw_rise[0] high 1 cycle; sw_fall stays 0; other channels unchanged.
//  3 Bounce ch1: toggle sw_raw[1] every 5 cycles for 60 cycles, then hold 0 -> sw_db[1] stays 0; no rise/fall pulses.
//  4 Release: ch0 1->0 held -> sw_fall[0] single pulse; sw_db[0]=0; sw_rise=0 throughout.
//  5 Simultaneous: sw_raw 8'h00->8'hA5 in one cycle -> sw_db=8'hA5; sw_rise=8'hA5 in one cycle.
//  6 Reset mid-filter: assert rst after 2 differing ticks -> sw_db stays 0, no pulse.
//    After release the full 3 ticks are required again.

Source files
------------

// File: rtl/switch_debounce.sv
// Per-channel switch conditioner: 2-FF synchroniser followed by a tick-sampled
// debounce filter, with registered clean levels and single-cycle rise/fall pulses.
module switch_debounce #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned TICKDIV      = 10000,
   parameter int unsigned STABLE_TICKS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             tick
);

   localparam int unsigned PW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
   localparam int unsigned CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICKDIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [PW-1:0]    presc;
   logic [CW-1:0]    cnt [WIDTH];

   // Synchroniser and sample-tick prescaler
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= '0;
         s2    <= '0;
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         s1    <= sw_raw;
         s2    <= s1;
         tick  <= (presc == PRE_LAST);
         presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
      end
   end

   // Debounce filter: a level is accepted after STABLE_TICKS consecutive differing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_db   <= '0;
         sw_rise <= '0;
         sw_fall <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sw_rise <= '0;
         sw_fall <= '0;
         if (tick) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
               if (s2[i] == sw_db[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == CNT_LAST) begin
                  sw_db[i]   <= s2[i];
                  sw_rise[i] <= s2[i];
                  sw_fall[i] <= ~s2[i];
                  cnt[i]     <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: table vectors, directed corner sequences and
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_switch_debounce;

   localparam int unsigned WIDTH        = 8;
   localparam int unsigned TICKDIV      = 4;
   localparam int unsigned STABLE_TICKS = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] sw_raw = '0;
   logic [WIDTH-1:0] sw_db;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             tick;

   int checks = 0;
   int errors = 0;

   switch_debounce #(
      .WIDTH(WIDTH), .TICKDIV(TICKDIV), .STABLE_TICKS(STABLE_TICKS)
   ) dut (
      .clk(clk), .rst(rst), .sw_raw(sw_raw),
      .sw_db(sw_db), .sw_rise(sw_rise), .sw_fall(sw_fall), .tick(tick)
   );

   always #5 clk = ~clk;

   // Behavioural model: raw input seen two cycles late, a tick every TICKDIV
   // cycles since reset, and a run length of disagreeing samples per channel.
   logic [WIDTH-1:0] hist [$];
   int unsigned      since;
   logic             m_tick;
   logic [WIDTH-1:0] m_db, m_rise, m_fall;
   int               run [WIDTH];

   function automatic void model_reset();
      hist = '{};
      hist.push_back('0);
      hist.push_back('0);
      since  = 0;
      m_tick = 1'b0;
      m_db   = '0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < int'(WIDTH); i++) run[i] = 0;
   endfunction

   function automatic void model_edge(input logic [WIDTH-1:0] raw, input logic r);
      logic [WIDTH-1:0] seen;
      if (r) begin
         model_reset();
         return;
      end
      seen   = hist[0];
      m_rise = '0;
      m_fall = '0;
      if (m_tick) begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (seen[i] == m_db[i]) begin
               run[i] = 0;
            end else begin
               run[i]++;
               if (run[i] >= int'(STABLE_TICKS)) begin
                  m_db[i]   = seen[i];
                  m_rise[i] = seen[i];
                  m_fall[i] = ~seen[i];
                  run[i]    = 0;
               end
            end
         end
      end
      void'(hist.pop_front());
      hist.push_back(raw);
      since++;
      m_tick = (since % TICKDIV) == 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance model, compare all outputs just after the edge
   task automatic step(input logic [WIDTH-1:0] raw, input logic r);
      sw_raw = raw;
      rst    = r;
      @(posedge clk);
      model_edge(raw, r);
      #1;
      checks++;
      if ({sw_db, sw_rise, sw_fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
         errors++;
         $display("FAIL cycle_model: db/rise/fall/tick got %h/%h/%h/%b expected %h/%h/%h/%b at %0t",
                  sw_db, sw_rise, sw_fall, tick, m_db, m_rise, m_fall, m_tick, $time);
      end
   endtask

   task automatic hold(input logic [WIDTH-1:0] raw, input int n);
      for (int k = 0; k < n; k++) step(raw, 1'b0);
   endtask

   typedef struct {
      logic [WIDTH-1:0] raw;
      int               cycles;
      logic [WIDTH-1:0] exp_db;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int first, n_rise, n_fall, n_other, n_tick;
      logic [WIDTH-1:0] r;

      tbl[0] = '{8'h00, 16, 8'h00};
      tbl[1] = '{8'h5A,  6, 8'h00};   // too short to be accepted
      tbl[2] = '{8'h00, 16, 8'h00};
      tbl[3] = '{8'h5A, 16, 8'h5A};
      tbl[4] = '{8'hFF, 16, 8'hFF};
      tbl[5] = '{8'h3C,  9, 8'hFF};
      tbl[6] = '{8'h3C, 16, 8'h3C};
      tbl[7] = '{8'h00, 16, 8'h00};

      model_reset();

      // 1: reset with inputs high, then settle to all ones
      for (int k = 0; k < 3; k++) begin
         step(8'hFF, 1'b1);
         chk("reset_db", 32'(sw_db), 32'h0);
         chk("reset_pulses", 32'({sw_rise, sw_fall, tick}), 32'h0);
      end
      first = -1; n_rise = 0; n_other = 0; n_tick = 0;
      for (int k = 1; k <= 20; k++) begin
         step(8'hFF, 1'b0);
         if (tick) n_tick++;
         if (k == 4 || k == 8) chk("tick_period", 32'(tick), 32'h1);
         if (first < 0 && sw_db == 8'hFF) first = k;
         if (sw_rise == 8'hFF) n_rise++;
         else if (sw_rise != 8'h00) n_other++;
      end
      chk("t1_db_latency_le14", 32'(first >= 1 && first <= 14), 32'h1);
      chk("t1_rise_once", 32'(n_rise), 32'd1);
      chk("t1_rise_partial", 32'(n_other), 32'd0);
      chk("t1_tick_count", 32'(n_tick), 32'd5);

      // 2: clean press on ch0
      hold(8'h00, 20);
      chk("t2_pre_db", 32'(sw_db), 32'h00);
      first = -1; n_rise = 0; n_fall = 0;
      for (int k = 1; k <= 25; k++) begin
         step(8'h01, 1'b0);
         if (first < 0 && sw_db[0]) first = k;
         if (sw_rise[0]) n_rise++;
         if (sw_fall != '0 || sw_rise[7:1] != '0 || sw_db[7:1] != '0) n_fall++;
      end
      chk("t2_latency_min", 32'(first >= 11), 32'h1);
      chk("t2_latency_max", 32'(first >= 0 && first <= 14), 32'h1);
      chk("t2_rise_once", 32'(n_rise), 32'd1);
      chk("t2_no_side_effects", 32'(n_fall), 32'd0);

      // 3: bounce on ch1 every 5 cycles, then hold low
      n_other = 0;
      for (int k = 0; k < 60; k++) begin
         step(((k / 5) % 2 == 0) ? 8'h03 : 8'h01, 1'b0);
         if (sw_rise[1] || sw_fall[1] || sw_db[1]) n_other++;
      end
      for (int k = 0; k < 20; k++) begin
         step(8'h01, 1'b0);
         if (sw_rise[1] || sw_fall[1] || sw_db[1]) n_other++;
      end
      chk("t3_bounce_rejected", 32'(n_other), 32'd0);

      // 4: release ch0
      n_fall = 0; n_rise = 0;
      for (int k = 0; k < 25; k++) begin
         step(8'h00, 1'b0);
         if (sw_fall[0]) n_fall++;
         if (sw_rise != '0) n_rise++;
      end
      chk("t4_fall_once", 32'(n_fall), 32'd1);
      chk("t4_no_rise", 32'(n_rise), 32'd0);
      chk("t4_db", 32'(sw_db), 32'h00);

      // 5: simultaneous change on several channels
      n_rise = 0; n_other = 0;
      for (int k = 0; k < 25; k++) begin
         step(8'hA5, 1'b0);
         if (sw_rise == 8'hA5) n_rise++;
         else if (sw_rise != 8'h00) n_other++;
      end
      chk("t5_rise_together", 32'(n_rise), 32'd1);
      chk("t5_rise_split", 32'(n_other), 32'd0);
      chk("t5_db", 32'(sw_db), 32'hA5);

      // 6: reset after two differing samples discards the partial count
      hold(8'h00, 20);
      first = 0;
      while (run[0] != 2 && first < 30) begin
         step(8'hFF, 1'b0);
         first++;
      end
      chk("t6_reached_two_samples", 32'(run[0]), 32'd2);
      for (int k = 0; k < 2; k++) begin
         step(8'hFF, 1'b1);
         chk("t6_reset_db", 32'(sw_db), 32'h0);
         chk("t6_reset_pulses", 32'({sw_rise, sw_fall}), 32'h0);
      end
      first = -1;
      for (int k = 1; k <= 20; k++) begin
         step(8'hFF, 1'b0);
         if (first < 0 && sw_db == 8'hFF) first = k;
      end
      chk("t6_full_restart", 32'(first), 32'd13);

      // Table-driven vectors
      foreach (tbl[v]) begin
         hold(tbl[v].raw, tbl[v].cycles);
         chk($sformatf("tbl%0d_db", v), 32'(sw_db), 32'(tbl[v].exp_db));
      end

      // Randomized: random levels, short bursts and occasional resets
      for (int it = 0; it < 400; it++) begin
         r = 8'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(r, 1'b1);
         end else begin
            hold(r, int'($urandom_range(1, 16)));
         end
      end
      hold(8'h00, 20);
      chk("final_db", 32'(sw_db), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
